micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Microprogram sequencer that sits directly upstream of the control-signal decoder in the processor control unit. It owns the micro-program counter (uPC), drives the control-ROM address, registers the fetched 36-bit microinstruction onto the decoder's ROMIN input, and selects the next address from the decoder's NXTADD output, the ALU zero flag and a 2-bit sequencing field in the microinstruction. Each microinstruction takes three cycles: fetch, execute, sequence.

## Interface

Parameters:
- ADDR_W, 5: uPC / ROM address width; must match the decoder's NXTADD width.
- WORD_W, 36: microinstruction width; must match the decoder's ROMIN width.
- START_ADDR, 0: uPC value loaded on start.
- FETCH_ADDR, 1: uPC value loaded by a RET sequencing code (macro-instruction fetch routine).
- CNT_W, 16: retired-microinstruction counter width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin execution at START_ADDR; sampled only in IDLE or HALT.
- hold  in  1  stall request (memory not ready); sampled only in EXEC.
- z_flag  in  1  ALU zero flag, sampled in SEQ.
- nxtadd  in  ADDR_W  next-address field from the decoder, sampled in SEQ.
- rom_data  in  WORD_W  combinational control-ROM read data for rom_addr.
- rom_addr  out  ADDR_W  control-ROM address; equals uPC.
- romin  out  WORD_W  registered microinstruction to the decoder.
- busy  out  1  high in FETCH, EXEC and SEQ.
- halted  out  1  high in HALT.
- retired  out  CNT_W  count of completed microinstructions; saturates.

## Operation

- Sequencing field: seq = romin[WORD_W-1:WORD_W-2], captured together with romin.
  - 00 JMP: next uPC = nxtadd.
  - 01 BRZ: next uPC = nxtadd if z_flag = 1, else uPC+1 (mod 2^ADDR_W, so 31 wraps to 0).
  - 10 RET: next uPC = FETCH_ADDR.
  - 11 HLT: go to HALT; uPC unchanged.
- The FSM has four execution states plus HALT:
  - IDLE: start=1 loads uPC=START_ADDR and goes to FETCH.
  - FETCH: romin <= rom_data (address = uPC), then go to EXEC.
  - EXEC: romin is held stable for the decoder to register. If hold=1, stay in EXEC; otherwise go to SEQ.
  - SEQ: compute the next uPC per seq and increment retired (saturating at 2^CNT_W-1). Go to FETCH, or to HALT for HLT.
  - HALT: romin is cleared to 0 on entry. start=1 loads uPC=START_ADDR, clears retired to 0 and goes to FETCH.
- start is ignored in FETCH, EXEC and SEQ.
- Only the uPC→rom_addr path is combinational; all other outputs are registered.

## Timing

- Reset values: state=IDLE, uPC=0, rom_addr=0, romin=0, busy=0, halted=0, retired=0.
- Reset mid-operation returns every output to its reset value immediately (asynchronously), including during a hold stall.
- Start to first romin: start is high at edge N, giving FETCH at N+1. romin is valid after edge N+2 and is held through EXEC.
- Unstalled throughput is one microinstruction per 3 cycles. Each cycle of hold adds one cycle.
- The decoder registers romin at the end of EXEC, so its nxtadd is valid during SEQ, which is the cycle in which the sequencer samples it.
- retired and the new uPC update on the same edge (the SEQ→next-state edge).
- halted rises on the edge leaving SEQ with HLT. busy is low in that same cycle.
- romin changes only on FETCH edges and on HALT entry. It never changes during EXEC, even under hold.

## Test plan

- Reset/idle: assert reset low mid-EXEC with romin ≠ 0 → all outputs return to 0 immediately; with start=0, the block stays IDLE for 10 cycles.
- JMP chain: ROM[0]=seq 00, the decoder returns nxtadd=7, ROM[7]=HLT → rom_addr sequence 0,7. halted=1 after 6 cycles from the FETCH at address 0; retired=2; romin=0 in HALT.
- BRZ both ways: at uPC=4 with nxtadd=20, z_flag=1 → next rom_addr=20; at uPC=31 with z_flag=0 → rom_addr wraps to 0.
- RET: RET at uPC=12 → next rom_addr=FETCH_ADDR=1.
- Hold: hold=1 for 3 cycles in EXEC → romin is stable for 4 cycles, SEQ is delayed by 3 cycles, retired increments by exactly 1.
- Restart/saturation: with CNT_W=2, run a 5-instruction loop → retired saturates at 3. start in HALT → retired=0, first rom_addr=0. start pulsed while busy → no effect.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the uPC, fetches control-ROM words onto romin and picks the next address.
// Latency: 3 cycles per microinstruction (FETCH/EXEC/SEQ); hold stretches EXEC one cycle per cycle asserted.
module micro_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int WORD_W     = 36,
    parameter int START_ADDR = 0,
    parameter int FETCH_ADDR = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    input  logic              z_flag,
    input  logic [ADDR_W-1:0] nxtadd,
    input  logic [WORD_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] romin,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_SEQ,
        S_HALT
    } state_t;

    localparam logic [1:0] SEQ_JMP = 2'b00;
    localparam logic [1:0] SEQ_BRZ = 2'b01;
    localparam logic [1:0] SEQ_RET = 2'b10;
    localparam logic [1:0] SEQ_HLT = 2'b11;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   upc, upc_nxt;
    logic [WORD_W-1:0]   romin_nxt;
    logic [CNT_W-1:0]    retired_nxt;
    logic                busy_nxt, halted_nxt;
    logic [1:0]          seq;

    assign seq      = romin[WORD_W-1:WORD_W-2];
    assign rom_addr = upc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            upc     <= '0;
            romin   <= '0;
            retired <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            upc     <= upc_nxt;
            romin   <= romin_nxt;
            retired <= retired_nxt;
            busy    <= busy_nxt;
            halted  <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        upc_nxt     = upc;
        romin_nxt   = romin;
        retired_nxt = retired;
        case (state)
            S_IDLE: begin
                if (start) begin
                    upc_nxt   = ADDR_W'(START_ADDR);
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                romin_nxt = rom_data;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (!hold) state_nxt = S_SEQ;
            end
            S_SEQ: begin
                if (retired != '1) retired_nxt = retired + 1'b1;
                state_nxt = S_FETCH;
                case (seq)
                    SEQ_JMP: upc_nxt = nxtadd;
                    SEQ_BRZ: upc_nxt = z_flag ? nxtadd : upc + 1'b1;
                    SEQ_RET: upc_nxt = ADDR_W'(FETCH_ADDR);
                    SEQ_HLT: begin
                        // The decoder sees an all-zero word while parked.
                        romin_nxt = '0;
                        state_nxt = S_HALT;
                    end
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_HALT: begin
                if (start) begin
                    upc_nxt     = ADDR_W'(START_ADDR);
                    retired_nxt = '0;
                    state_nxt   = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt   = (state_nxt == S_FETCH) || (state_nxt == S_EXEC) || (state_nxt == S_SEQ);
        halted_nxt = (state_nxt == S_HALT);
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: ROM/decoder model plus a queue of expected fetch addresses.
module tb_micro_sequencer;

    localparam int ADDR_W = 5;
    localparam int WORD_W = 36;
    localparam int CNT_W  = 2;

    localparam logic [1:0] JMP = 2'b00;
    localparam logic [1:0] BRZ = 2'b01;
    localparam logic [1:0] RET = 2'b10;
    localparam logic [1:0] HLT = 2'b11;

    logic              clk;
    logic              reset;
    logic              start;
    logic              hold;
    logic              z_flag;
    logic [ADDR_W-1:0] nxtadd;
    logic [WORD_W-1:0] rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] romin;
    logic              busy;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    logic [WORD_W-1:0] rom [32];
    logic [ADDR_W-1:0] exp_q [$];
    int                exp_ret;
    int                n_pass;
    int                n_fail;
    int                n_tot;

    micro_sequencer #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .START_ADDR(0), .FETCH_ADDR(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .z_flag(z_flag),
        .nxtadd(nxtadd), .rom_data(rom_data), .rom_addr(rom_addr), .romin(romin),
        .busy(busy), .halted(halted), .retired(retired)
    );

    // Control ROM is combinational; the decoder returns the low address bits of the word it registered.
    assign rom_data = rom[rom_addr];
    assign nxtadd   = romin[ADDR_W-1:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WORD_W-1:0] mk(input logic [1:0] s, input logic [4:0] nxt, input logic [7:0] tag);
        return {s, 21'd0, tag, nxt};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Entered at the negedge of a FETCH cycle; leaves at the negedge after the SEQ edge.
    task automatic run_instr(input int holds, input logic z, input logic pulse_start);
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] w;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            a = rom_addr;
        end else begin
            a = exp_q.pop_front();
        end
        chk("fetch_busy", busy, 1);
        chk("fetch_halted", halted, 0);
        chk("fetch_addr", rom_addr, a);
        chk("fetch_retired", retired, exp_ret);
        w = rom[a];
        start = pulse_start;
        step();
        chk("exec_romin", romin, w);
        for (int i = 0; i < holds; i++) begin
            hold = 1'b1;
            step();
            chk("hold_romin", romin, w);
            chk("hold_retired", retired, exp_ret);
            chk("hold_busy", busy, 1);
        end
        hold   = 1'b0;
        z_flag = z;
        step();
        chk("seq_romin", romin, w);
        chk("seq_busy", busy, 1);
        step();
        start   = 1'b0;
        exp_ret = (exp_ret == 3) ? 3 : exp_ret + 1;
        if (w[WORD_W-1:WORD_W-2] == HLT) begin
            chk("hlt_halted", halted, 1);
            chk("hlt_busy", busy, 0);
            chk("hlt_romin", romin, 0);
            chk("hlt_retired", retired, exp_ret);
        end
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_tot = 0; exp_ret = 0;
        reset = 1'b0; start = 1'b0; hold = 1'b0; z_flag = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = '0;

        // Power-on reset, then idle with start low.
        step(); step();
        chk("rst_addr", rom_addr, 0);
        chk("rst_romin", romin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_busy", busy, 0);
            chk("idle_addr", rom_addr, 0);
        end

        // JMP chain 0 -> 7 -> HLT.
        rom[0] = mk(JMP, 5'd7, 8'd1);
        rom[7] = mk(HLT, 5'd0, 8'd8);
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd7);
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(0, 1'b0, 1'b0);
        run_instr(0, 1'b0, 1'b0);
        chk("jmp_retired", retired, 2);
        step(); step();
        chk("halt_stays", halted, 1);
        chk("halt_addr", rom_addr, 7);

        // Restart from HALT: RET, hold, BRZ taken, BRZ wrap, saturation, start ignored while busy.
        rom[0]  = mk(JMP, 5'd12, 8'd1);
        rom[12] = mk(RET, 5'd0,  8'd13);
        rom[1]  = mk(JMP, 5'd4,  8'd2);
        rom[4]  = mk(BRZ, 5'd20, 8'd5);
        rom[20] = mk(JMP, 5'd31, 8'd21);
        rom[31] = mk(BRZ, 5'd9,  8'd32);
        foreach (rom[i]) if (i == 0) exp_q.push_back(5'd0);
        exp_q.push_back(5'd12);
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd4);
        exp_q.push_back(5'd20);
        exp_q.push_back(5'd31);
        exp_q.push_back(5'd0);
        exp_ret = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(0, 1'b0, 1'b1);
        rom[0] = mk(HLT, 5'd0, 8'd99);
        run_instr(3, 1'b0, 1'b0);
        run_instr(0, 1'b0, 1'b0);
        run_instr(0, 1'b1, 1'b0);
        run_instr(0, 1'b1, 1'b1);
        run_instr(0, 1'b0, 1'b0);
        run_instr(0, 1'b0, 1'b0);
        chk("sat_retired", retired, 3);
        chk("queue_drained", exp_q.size(), 0);

        // Asynchronous reset during a hold stall in EXEC.
        rom[0] = mk(JMP, 5'd7, 8'd1);
        rom[7] = mk(JMP, 5'd0, 8'd8);
        exp_q.push_back(5'd0);
        exp_ret = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(0, 1'b0, 1'b0);
        chk("pre_rst_addr", rom_addr, 7);
        step();
        chk("pre_rst_romin", romin, mk(JMP, 5'd0, 8'd8));
        hold = 1'b1;
        step();
        #3 reset = 1'b0;
        #1;
        chk("arst_addr", rom_addr, 0);
        chk("arst_romin", romin, 0);
        chk("arst_busy", busy, 0);
        chk("arst_halted", halted, 0);
        chk("arst_retired", retired, 0);
        hold = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle2_busy", busy, 0);
            chk("idle2_romin", romin, 0);
            chk("idle2_addr", rom_addr, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
